// File: rtl/rc4_search_scheduler_if.sv
// Bundle of control, core-array and result signals for the rc4 key-search scheduler.
// master = scheduler side, slave = top-level control / core array side.
interface rc4_search_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = 22
);
  logic                         start;
  logic                         abort;
  logic [NUM_CORES-1:0]         core_start;
  logic                         core_stop_all;
  logic [8*NUM_CORES-1:0]       core_init_val;
  logic [7:0]                   total_cores;
  logic [NUM_CORES-1:0]         core_found;
  logic [NUM_CORES-1:0]         core_exhausted;
  logic [KEY_W*NUM_CORES-1:0]   core_key;
  logic                         busy;
  logic                         key_found;
  logic                         no_key;
  logic                         aborted;
  logic [KEY_W-1:0]             found_key;
  logic [7:0]                   found_core;
  logic [31:0]                  run_cycles;

  modport master (
    input  start, abort, core_found, core_exhausted, core_key,
    output core_start, core_stop_all, core_init_val, total_cores,
           busy, key_found, no_key, aborted, found_key, found_core, run_cycles
  );

  modport slave (
    output start, abort, core_found, core_exhausted, core_key,
    input  core_start, core_stop_all, core_init_val, total_cores,
           busy, key_found, no_key, aborted, found_key, found_core, run_cycles
  );
endinterface

// File: rtl/rc4_search_scheduler.sv
// Launches a bank of rc4 brute-force cores one per cycle, then picks a single winner,
// detects exhaustion or abort, broadcasts stop and latches the result.
module rc4_search_scheduler #(
  parameter int NUM_CORES   = 4,
  parameter int KEY_W       = 22,
  parameter int STOP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rc4_search_scheduler_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [7:0]           LAST_IDX  = 8'(NUM_CORES - 1);
  localparam logic [15:0]          LAST_STOP = 16'(STOP_CYCLES - 1);
  localparam logic [NUM_CORES-1:0] ALL_EXH   = '1;

  function automatic logic [7:0] lowest_set(input logic [NUM_CORES-1:0] v);
    lowest_set = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--)
      if (v[i]) lowest_set = 8'(i);
  endfunction

  function automatic logic [KEY_W-1:0] key_of(input logic [KEY_W*NUM_CORES-1:0] keys,
                                              input logic [7:0] sel);
    key_of = '0;
    for (int i = 0; i < NUM_CORES; i++)
      if (sel == 8'(i)) key_of = keys[i*KEY_W +: KEY_W];
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [2:0]           state;
  logic [7:0]           idx;
  logic [15:0]          stop_cnt;
  logic [NUM_CORES-1:0] exh_mask;
  logic                 any_found;
  logic [7:0]           win_idx;
  logic [NUM_CORES-1:0] mask_next;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_init
    assign bus.core_init_val[8*g +: 8] = 8'(g);
  end
  assign bus.total_cores = 8'(NUM_CORES);

  always_comb begin
    any_found = |bus.core_found;
    win_idx   = lowest_set(bus.core_found);
    mask_next = exh_mask | bus.core_exhausted;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      idx               <= '0;
      stop_cnt          <= '0;
      exh_mask          <= '0;
      bus.core_start    <= '0;
      bus.core_stop_all <= 1'b0;
      bus.busy          <= 1'b0;
      bus.key_found     <= 1'b0;
      bus.no_key        <= 1'b0;
      bus.aborted       <= 1'b0;
      bus.found_key     <= '0;
      bus.found_core    <= '0;
      bus.run_cycles    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state          <= S_LAUNCH;
            idx            <= '0;
            exh_mask       <= '0;
            bus.core_start <= NUM_CORES'(1);
            bus.busy       <= 1'b1;
            bus.key_found  <= 1'b0;
            bus.no_key     <= 1'b0;
            bus.aborted    <= 1'b0;
            bus.found_key  <= '0;
            bus.found_core <= '0;
            bus.run_cycles <= '0;
          end
        end
        S_LAUNCH, S_RUN: begin
          bus.run_cycles <= sat_inc(bus.run_cycles);
          exh_mask       <= mask_next;
          // Terminating events in priority order: find, abort, exhaustion.
          if (any_found) begin
            bus.key_found     <= 1'b1;
            bus.found_key     <= key_of(bus.core_key, win_idx);
            bus.found_core    <= win_idx;
            state             <= S_STOP;
            stop_cnt          <= '0;
            bus.core_start    <= '0;
            bus.core_stop_all <= 1'b1;
          end else if (bus.abort) begin
            bus.aborted       <= 1'b1;
            state             <= S_STOP;
            stop_cnt          <= '0;
            bus.core_start    <= '0;
            bus.core_stop_all <= 1'b1;
          end else if (mask_next == ALL_EXH) begin
            bus.no_key     <= 1'b1;
            state          <= S_DONE;
            bus.core_start <= '0;
            bus.busy       <= 1'b0;
          end else if (state == S_LAUNCH) begin
            if (idx == LAST_IDX) begin
              state          <= S_RUN;
              bus.core_start <= '0;
            end else begin
              idx            <= idx + 8'd1;
              bus.core_start <= NUM_CORES'(1) << (idx + 8'd1);
            end
          end
        end
        S_STOP: begin
          if (stop_cnt == LAST_STOP) begin
            state             <= S_DONE;
            bus.core_stop_all <= 1'b0;
            bus.busy          <= 1'b0;
          end else begin
            stop_cnt <= stop_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_search_scheduler.sv
// Randomized and directed bench for rc4_search_scheduler; each search is described by
// per-core find/exhaust cycles plus an abort cycle, and the outcome is predicted from those.
module tb_rc4_search_scheduler;
  localparam int N     = 4;
  localparam int KW    = 22;
  localparam int SC    = 4;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rc4_search_scheduler_if #(.NUM_CORES(N), .KEY_W(KW)) bus ();

  rc4_search_scheduler #(.NUM_CORES(N), .KEY_W(KW), .STOP_CYCLES(SC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Search schedule: cycle 0 is the first cycle after the start edge.
  int          f [N];
  int          e [N];
  int          a;
  bit          use_spur;
  bit          use_dkey;
  logic [KW-1:0] dkey [N];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.start          = 1'b0;
    bus.abort          = 1'b0;
    bus.core_found     = '0;
    bus.core_exhausted = '0;
    bus.core_key       = '0;
  endtask

  task automatic clear_sched();
    for (int i = 0; i < N; i++) begin
      f[i]    = NEVER;
      e[i]    = NEVER;
      dkey[i] = KW'($urandom);
    end
    a        = NEVER;
    use_spur = 1'b0;
    use_dkey = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".core_start"}, 64'(bus.core_start), 64'd0);
    check_eq({tag, ".stop_all"},   64'(bus.core_stop_all), 64'd0);
    check_eq({tag, ".busy"},       64'(bus.busy), 64'd0);
    check_eq({tag, ".flags"},      64'({bus.key_found, bus.no_key, bus.aborted}), 64'd0);
    check_eq({tag, ".found_key"},  64'(bus.found_key), 64'd0);
    check_eq({tag, ".found_core"}, 64'(bus.found_core), 64'd0);
    check_eq({tag, ".run_cycles"}, 64'(bus.run_cycles), 64'd0);
  endtask

  task automatic run_search(input string name);
    int t, t_exh, win, stop_len, s;
    bit done_find, done_abort, done_exh;
    logic [KW-1:0]   kv [N];
    logic [KW-1:0]   wkey;
    logic [N-1:0]    fv, ev, exp_start;
    logic [KW*N-1:0] kb;

    // Outcome prediction: earliest of first find, abort, last exhaustion.
    t = a; t_exh = 0; win = -1; wkey = '0;
    for (int i = 0; i < N; i++) begin
      if (f[i] < t) t = f[i];
      if (e[i] > t_exh) t_exh = e[i];
    end
    if (t_exh < t) t = t_exh;
    for (int i = N - 1; i >= 0; i--) if (f[i] == t) win = i;
    done_find  = (win >= 0);
    done_abort = !done_find && (a == t);
    done_exh   = !done_find && !done_abort;
    stop_len   = done_exh ? 0 : SC;
    s = use_spur ? int'($urandom_range(32'(t + stop_len))) : NEVER;

    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 0; k <= t + stop_len + 2; k++) begin
      @(negedge clk);
      exp_start = (k < N && k <= t) ? (N'(1) << k) : '0;
      check_eq({name, ".core_start"}, 64'(bus.core_start), 64'(exp_start));
      check_eq({name, ".busy"},       64'(bus.busy), 64'(k <= t + stop_len));
      check_eq({name, ".stop_all"},   64'(bus.core_stop_all),
               64'(!done_exh && k > t && k <= t + stop_len));
      check_eq({name, ".run_cycles"}, 64'(bus.run_cycles), 64'((k <= t + 1) ? k : t + 1));
      check_eq({name, ".key_found"},  64'(bus.key_found), 64'(done_find && k > t));
      check_eq({name, ".aborted"},    64'(bus.aborted), 64'(done_abort && k > t));
      check_eq({name, ".no_key"},     64'(bus.no_key), 64'(done_exh && k > t));
      check_eq({name, ".found_key"},  64'(bus.found_key), 64'((k > t) ? wkey : '0));
      check_eq({name, ".found_core"}, 64'(bus.found_core), 64'((done_find && k > t) ? win : 0));

      bus.start = (k == s);
      for (int i = 0; i < N; i++) begin
        if (k <= t) begin
          fv[i] = (f[i] == k);
          ev[i] = (e[i] == k);
        end else begin
          fv[i] = 1'($urandom);
          ev[i] = 1'($urandom);
        end
        kv[i] = (use_dkey && k == t) ? dkey[i] : KW'($urandom);
        kb[i*KW +: KW] = kv[i];
      end
      if (k == t && done_find) wkey = kv[win];
      bus.abort          = (k <= t) ? (a == k) : 1'($urandom);
      bus.core_found     = fv;
      bus.core_exhausted = ev;
      bus.core_key       = kb;
    end
    idle_inputs();
  endtask

  task automatic reset_mid(input string name, input int fc, input int wait_cyc,
                           input bit stop_pre);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < wait_cyc; k++) begin
      bus.core_found = (k == fc) ? N'(1) : '0;
      @(negedge clk);
    end
    bus.core_found = '0;
    check_eq({name, ".pre_busy"}, 64'(bus.busy), 64'd1);
    check_eq({name, ".pre_stop"}, 64'(bus.core_stop_all), 64'(stop_pre));
    reset_n = 1'b0;
    #1;
    check_all_zero(name);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [8*N-1:0] exp_init;
    reset_n = 1'b0;
    idle_inputs();
    clear_sched();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    for (int i = 0; i < N; i++) exp_init[8*i +: 8] = 8'(i);
    check_eq("core_init_val", 64'(bus.core_init_val), 64'(exp_init));
    check_eq("total_cores",   64'(bus.total_cores), 64'(N));
    reset_n = 1'b1;

    clear_sched(); f[2] = 20; use_dkey = 1'b1; dkey[2] = 22'h1A2B3C;
    run_search("normal_find");

    clear_sched(); f[1] = 10; f[3] = 10; use_dkey = 1'b1;
    dkey[1] = 22'h0ABCDE; dkey[3] = 22'h3FFFFF;
    run_search("simul_find");

    clear_sched(); e[0] = 5; e[1] = 12; e[2] = 3; e[3] = 17;
    run_search("exhaust");

    clear_sched(); f[0] = 8; a = 8; e[1] = 8;
    run_search("abort_vs_find");

    clear_sched(); a = 9;
    run_search("abort_only");

    clear_sched(); f[0] = 1;
    run_search("launch_find");

    clear_sched(); f[1] = 15; use_spur = 1'b1;
    run_search("spur_start");

    clear_sched();
    reset_mid("rst_run", NEVER, 8, 1'b0);
    reset_mid("rst_stop", 3, 6, 1'b1);

    clear_sched(); e[0] = 2; e[1] = 2; e[2] = 2; e[3] = 2; a = 2;
    run_search("abort_vs_exh");

    for (int it = 0; it < 40; it++) begin
      clear_sched();
      for (int i = 0; i < N; i++) begin
        f[i] = ($urandom_range(1) == 1) ? int'($urandom_range(40)) : NEVER;
        e[i] = ($urandom_range(9) < 7) ? int'($urandom_range(40)) : NEVER;
      end
      a        = int'($urandom_range(60));
      use_spur = 1'($urandom);
      use_dkey = 1'b0;
      run_search("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
